// File: rtl/route_arbiter_if.sv
// Handshake bundle between the input buffers, the route arbiter and the
// routing/allocation engine. The master side is the arbiter itself.
interface route_arbiter_if #(
  parameter int NPORT    = 5,
  parameter int TAM_FLIT = 16
);
  localparam int SRC_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0]          h;
  logic [NPORT-1:0]          ack_h;
  logic [NPORT*TAM_FLIT-1:0] data_in;
  logic                      route_req;
  logic [TAM_FLIT-1:0]       route_header;
  logic [SRC_W-1:0]          route_src;
  logic                      route_done;
  logic                      route_ok;
  logic                      route_fail;
  logic                      timeout_err;
  logic                      busy;

  modport master (
    input  h, data_in, route_done, route_ok,
    output ack_h, route_req, route_header, route_src,
           route_fail, timeout_err, busy
  );

  modport slave (
    output h, data_in, route_done, route_ok,
    input  ack_h, route_req, route_header, route_src,
           route_fail, timeout_err, busy
  );
endinterface

// File: rtl/route_arbiter.sv
// Round-robin arbiter feeding one routing engine from NPORT input buffers.
// A winning header is latched and held on route_header while route_req is
// high; the engine answers with route_done/route_ok, or the request is
// aborted after TIMEOUT cycles or when the buffer withdraws its header.
module route_arbiter #(
  parameter int NPORT    = 5,
  parameter int TAM_FLIT = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic            clock,
  input  logic            reset,
  route_arbiter_if.master bus
);
  localparam int SRC_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [TAM_FLIT-1:0] hdr_q, hdr_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic                fail_q, fail_d;
  logic                tout_q, tout_d;
  logic [SRC_W-1:0]    win;
  logic [NPORT-1:0]    ack;

  // First requesting port after 'last', wrapping NPORT-1 -> 0.
  function automatic logic [SRC_W-1:0] rr_winner(input logic [NPORT-1:0] req,
                                                 input logic [SRC_W-1:0] last);
    logic [SRC_W-1:0] w;
    logic             found;
    int               idx;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = (int'(last) + k) % NPORT;
      if (!found && req[idx]) begin
        w     = SRC_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Round-robin candidate for the next grant.
  always_comb begin
    win = rr_winner(bus.h, ptr_q);
  end

  // Next-state, pointer, header latch and abort-pulse decisions.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    hdr_d   = hdr_q;
    tcnt_d  = tcnt_q;
    fail_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.h) begin
          src_d   = win;
          hdr_d   = bus.data_in[int'(win)*TAM_FLIT +: TAM_FLIT];
          tcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        tcnt_d = tcnt_q + CNT_W'(1);
        // Engine answer outranks both the timeout and a withdrawn header.
        if (bus.route_done) begin
          if (bus.route_ok) begin
            state_d = ACK;
          end else begin
            fail_d  = 1'b1;
            ptr_d   = src_q;
            state_d = IDLE;
          end
        end else if (tcnt_q == CNT_W'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          ptr_d   = src_q;
          state_d = IDLE;
        end else if (!bus.h[src_q]) begin
          ptr_d   = src_q;
          state_d = IDLE;
        end
      end
      ACK: begin
        ptr_d   = src_q;
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset brings priority back to port 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= SRC_W'(NPORT - 1);
      src_q   <= '0;
      hdr_q   <= '0;
      tcnt_q  <= '0;
      fail_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      hdr_q   <= hdr_d;
      tcnt_q  <= tcnt_d;
      fail_q  <= fail_d;
      tout_q  <= tout_d;
    end
  end

  // One-hot grant-complete pulse to the served buffer while in ACK.
  always_comb begin
    ack = '0;
    if (state_q == ACK) ack[src_q] = 1'b1;
  end

  assign bus.ack_h        = ack;
  assign bus.route_req    = (state_q == REQ);
  assign bus.route_header = hdr_q;
  assign bus.route_src    = src_q;
  assign bus.route_fail   = fail_q;
  assign bus.timeout_err  = tout_q;
  assign bus.busy         = (state_q != IDLE);
endmodule
